// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the pipeline memory (M) stage.
//   mem_state_t    : bus access FSM states (MEM_IDLE, MEM_WAIT)
//   MEM_ABORT_DATA : load data written back when the watchdog aborts an access
//   BE_WORD        : byte-enable pattern for a full word access
package mem_pkg;

    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    localparam logic [31:0] MEM_ABORT_DATA = 32'hDEADBEEF;
    localparam logic [3:0]  BE_WORD        = 4'hF;

endpackage

// File: rtl/pipeMemWb.sv
// pipeMemWb: MEM/WB pipeline register between the memory and writeback stages.
// Ports:
//   clk, rst       : clock (rising edge) and asynchronous active-high reset to 0
//   bubble         : when high, W controls and the error flag load as 0
//   err            : watchdog abort flag for the access completing this cycle
//   pcsrc, regwrite, memtoreg : M-stage control to forward
//   aluout, rdata, wa3        : data fields to forward
//   *_w outputs    : registered W-stage values
module pipeMemWb
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  logic              err,
    input  logic              pcsrc,
    input  logic              regwrite,
    input  logic              memtoreg,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] rdata,
    input  logic [3:0]        wa3,
    output logic              pcsrc_w,
    output logic              regwrite_w,
    output logic              memtoreg_w,
    output logic              err_w,
    output logic [DATA_W-1:0] aluout_w,
    output logic [DATA_W-1:0] rdata_w,
    output logic [3:0]        wa3_w
);

    // M -> W boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcsrc_w    <= 1'b0;
            regwrite_w <= 1'b0;
            memtoreg_w <= 1'b0;
            err_w      <= 1'b0;
            aluout_w   <= '0;
            rdata_w    <= '0;
            wa3_w      <= '0;
        end else begin
            pcsrc_w    <= pcsrc    & ~bubble;
            regwrite_w <= regwrite & ~bubble;
            memtoreg_w <= memtoreg & ~bubble;
            err_w      <= err      & ~bubble;
            aluout_w   <= aluout;
            rdata_w    <= rdata;
            wa3_w      <= wa3;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: M stage of the ARM pipeline. Drives the data memory / camera
// bus with a req/ack handshake, stalls on slow accesses, aborts hung accesses
// with a watchdog and holds the MEM/WB register.
// Ports:
//   Clk, reset                 : clock, asynchronous active-high reset
//   PCSrcM..WA3M               : M-stage control and data from EX/MEM
//   MemReqOut..MemBeOut        : bus request, write enable, address, data, byte enables
//   MemRdataIn, MemAckIn       : bus read data and acknowledge
//   StallMout                  : freeze request to the hazard unit
//   ALUOutMout                 : ALUOutM forwarded to E stage
//   *Wout                      : MEM/WB register outputs; MemErrWout flags an abort
// Optional build macro MEM_BYTE_EN adds input ByteM for byte loads/stores.
module memory_stage
    import mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              PCSrcM,
    input  logic              RegWriteM,
    input  logic              MemToRegM,
    input  logic              MemWriteM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [3:0]        WA3M,
`ifdef MEM_BYTE_EN
    input  logic              ByteM,
`endif
    output logic              MemReqOut,
    output logic              MemWeOut,
    output logic [DATA_W-1:0] MemAddrOut,
    output logic [DATA_W-1:0] MemWdOut,
    output logic [3:0]        MemBeOut,
    input  logic [DATA_W-1:0] MemRdataIn,
    input  logic              MemAckIn,
    output logic              StallMout,
    output logic [DATA_W-1:0] ALUOutMout,
    output logic              PCSrcWout,
    output logic              RegWriteWout,
    output logic              MemToRegWout,
    output logic [DATA_W-1:0] ReadDataWout,
    output logic [DATA_W-1:0] ALUOutWout,
    output logic [3:0]        WA3Wout,
    output logic              MemErrWout
);

    localparam int                CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_WAIT - 1);

    // Zero-extended byte from the addressed lane, or the whole word.
    function automatic logic [DATA_W-1:0] format_load(input logic [DATA_W-1:0] rdata,
                                                      input logic              is_byte,
                                                      input logic [1:0]        lane);
        logic [DATA_W-1:0] shifted;
        shifted = rdata >> {lane, 3'b000};
        format_load = is_byte ? {{(DATA_W-8){1'b0}}, shifted[7:0]} : rdata;
    endfunction

    // Store data replicated across all lanes for byte stores.
    function automatic logic [DATA_W-1:0] format_store(input logic [DATA_W-1:0] wdata,
                                                       input logic              is_byte);
        format_store = is_byte ? {(DATA_W/8){wdata[7:0]}} : wdata;
    endfunction

    function automatic logic [3:0] byte_enables(input logic is_byte, input logic [1:0] lane);
        byte_enables = is_byte ? (4'b0001 << lane) : BE_WORD;
    endfunction

    mem_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;

    // Hold registers: the access as presented in MEM_IDLE, replayed during MEM_WAIT.
    logic [DATA_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;
    logic              hold_we;
    logic              hold_pcsrc;
    logic              hold_regwrite;
    logic              hold_memtoreg;
    logic [3:0]        hold_wa3;

    logic              acc;
    logic              in_wait;
    logic              active;
    logic              timeout;
    logic              cur_byte;
    logic [DATA_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_we;
    logic              cur_pcsrc;
    logic              cur_regwrite;
    logic              cur_memtoreg;
    logic [3:0]        cur_wa3;

    logic              wb_bubble;
    logic              wb_pcsrc;
    logic              wb_regwrite;
    logic              wb_memtoreg;
    logic [DATA_W-1:0] wb_rdata;

    assign acc     = MemToRegM | MemWriteM;
    assign in_wait = (state_q == MEM_WAIT);
    assign active  = in_wait | acc;
    assign timeout = in_wait & ~MemAckIn & (cnt_q == CNT_LAST);

    // In MEM_WAIT the bus sees only the held copy, so upstream changes cannot
    // disturb an access in flight.
    assign cur_addr     = in_wait ? hold_addr     : ALUOutM;
    assign cur_wdata    = in_wait ? hold_wdata    : WriteDataM;
    assign cur_we       = in_wait ? hold_we       : MemWriteM;
    assign cur_pcsrc    = in_wait ? hold_pcsrc    : PCSrcM;
    assign cur_regwrite = in_wait ? hold_regwrite : RegWriteM;
    assign cur_memtoreg = in_wait ? hold_memtoreg : MemToRegM;
    assign cur_wa3      = in_wait ? hold_wa3      : WA3M;

`ifdef MEM_BYTE_EN
    logic hold_byte;
    assign cur_byte = in_wait ? hold_byte : ByteM;
`else
    assign cur_byte = 1'b0;
`endif

    // Reset gates the combinational handshake so the bus is released at once.
    assign MemReqOut  = ~reset & active;
    assign MemWeOut   = ~reset & active & cur_we;
    assign StallMout  = ~reset & active & ~MemAckIn & ~timeout;
    assign MemAddrOut = cur_addr;
    assign MemWdOut   = format_store(cur_wdata, cur_byte);
    assign MemBeOut   = byte_enables(cur_byte, cur_addr[1:0]);
    assign ALUOutMout = ALUOutM;

    // An abort completes the instruction with no architectural side effects.
    assign wb_bubble   = StallMout;
    assign wb_pcsrc    = cur_pcsrc    & ~timeout;
    assign wb_regwrite = cur_regwrite & ~timeout;
    assign wb_memtoreg = cur_memtoreg & ~timeout;

    always_comb begin
        wb_rdata = '0;
        if (timeout)
            wb_rdata = MEM_ABORT_DATA;
        else if (active)
            wb_rdata = format_load(MemRdataIn, cur_byte, cur_addr[1:0]);
    end

    // FSM and watchdog
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                MEM_IDLE: begin
                    if (acc && !MemAckIn) begin
                        state_q <= MEM_WAIT;
                        cnt_q   <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (MemAckIn || timeout) begin
                        state_q <= MEM_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= MEM_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Hold register capture at access start
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            hold_addr     <= '0;
            hold_wdata    <= '0;
            hold_we       <= 1'b0;
            hold_pcsrc    <= 1'b0;
            hold_regwrite <= 1'b0;
            hold_memtoreg <= 1'b0;
            hold_wa3      <= '0;
        end else if (!in_wait && acc) begin
            hold_addr     <= ALUOutM;
            hold_wdata    <= WriteDataM;
            hold_we       <= MemWriteM;
            hold_pcsrc    <= PCSrcM;
            hold_regwrite <= RegWriteM;
            hold_memtoreg <= MemToRegM;
            hold_wa3      <= WA3M;
        end
    end

`ifdef MEM_BYTE_EN
    always_ff @(posedge Clk or posedge reset) begin
        if (reset)
            hold_byte <= 1'b0;
        else if (!in_wait && acc)
            hold_byte <= ByteM;
    end
`endif

    pipeMemWb #(
        .DATA_W (DATA_W)
    ) u_mem_wb (
        .clk        (Clk),
        .rst        (reset),
        .bubble     (wb_bubble),
        .err        (timeout),
        .pcsrc      (wb_pcsrc),
        .regwrite   (wb_regwrite),
        .memtoreg   (wb_memtoreg),
        .aluout     (cur_addr),
        .rdata      (wb_rdata),
        .wa3        (cur_wa3),
        .pcsrc_w    (PCSrcWout),
        .regwrite_w (RegWriteWout),
        .memtoreg_w (MemToRegWout),
        .err_w      (MemErrWout),
        .aluout_w   (ALUOutWout),
        .rdata_w    (ReadDataWout),
        .wa3_w      (WA3Wout)
    );

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    logic        Clk = 1'b0;
    logic        reset;
    logic        PCSrcM, RegWriteM, MemToRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [3:0]  WA3M;
`ifdef MEM_BYTE_EN
    logic        ByteM;
`endif
    logic        MemReqOut, MemWeOut;
    logic [31:0] MemAddrOut, MemWdOut;
    logic [3:0]  MemBeOut;
    logic [31:0] MemRdataIn;
    logic        MemAckIn;
    logic        StallMout;
    logic [31:0] ALUOutMout;
    logic        PCSrcWout, RegWriteWout, MemToRegWout;
    logic [31:0] ReadDataWout, ALUOutWout;
    logic [3:0]  WA3Wout;
    logic        MemErrWout;

    int passed = 0;
    int total  = 0;

    always #5 Clk = ~Clk;

    memory_stage #(.DATA_W(32), .MAX_WAIT(4)) dut (
        .Clk(Clk), .reset(reset),
        .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WA3M(WA3M),
`ifdef MEM_BYTE_EN
        .ByteM(ByteM),
`endif
        .MemReqOut(MemReqOut), .MemWeOut(MemWeOut), .MemAddrOut(MemAddrOut),
        .MemWdOut(MemWdOut), .MemBeOut(MemBeOut), .MemRdataIn(MemRdataIn), .MemAckIn(MemAckIn),
        .StallMout(StallMout), .ALUOutMout(ALUOutMout),
        .PCSrcWout(PCSrcWout), .RegWriteWout(RegWriteWout), .MemToRegWout(MemToRegWout),
        .ReadDataWout(ReadDataWout), .ALUOutWout(ALUOutWout), .WA3Wout(WA3Wout),
        .MemErrWout(MemErrWout)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_idle();
        PCSrcM = 0; RegWriteM = 0; MemToRegM = 0; MemWriteM = 0;
        ALUOutM = 0; WriteDataM = 0; WA3M = 0; MemRdataIn = 0; MemAckIn = 0;
`ifdef MEM_BYTE_EN
        ByteM = 0;
`endif
    endtask

    task automatic test_reset();
        reset = 1; set_idle();
        tick(); tick();
        total++; if (MemReqOut !== 1'b0) $display("FAIL rst_req got=%0h exp=0", MemReqOut); else passed++;
        total++; if (StallMout !== 1'b0) $display("FAIL rst_stall got=%0h exp=0", StallMout); else passed++;
        total++; if ({PCSrcWout, RegWriteWout, MemToRegWout, MemErrWout} !== 4'b0) $display("FAIL rst_wctl got=%0h exp=0", {PCSrcWout, RegWriteWout, MemToRegWout, MemErrWout}); else passed++;
        total++; if ({ReadDataWout, ALUOutWout, WA3Wout} !== 68'h0) $display("FAIL rst_wdata got=%0h exp=0", {ReadDataWout, ALUOutWout, WA3Wout}); else passed++;
        reset = 0;
        ALUOutM = 32'h55; #1;
        total++; if (ALUOutMout !== 32'h55) $display("FAIL fwd_alu got=%0h exp=55", ALUOutMout); else passed++;
        set_idle(); tick();
    endtask

    task automatic test_zero_wait_load();
        ALUOutM = 32'h100; MemToRegM = 1; RegWriteM = 1; WA3M = 3;
        MemAckIn = 1; MemRdataIn = 32'hCAFEF00D; #1;
        total++; if ({MemReqOut, MemWeOut, StallMout} !== 3'b100) $display("FAIL zw_hs got=%0b exp=100", {MemReqOut, MemWeOut, StallMout}); else passed++;
        total++; if (MemAddrOut !== 32'h100 || MemBeOut !== 4'hF) $display("FAIL zw_bus got=%0h/%0h exp=100/f", MemAddrOut, MemBeOut); else passed++;
        tick();
        total++; if (ReadDataWout !== 32'hCAFEF00D) $display("FAIL zw_rdata got=%0h exp=cafef00d", ReadDataWout); else passed++;
        total++; if (WA3Wout !== 4'd3 || RegWriteWout !== 1'b1 || MemToRegWout !== 1'b1) $display("FAIL zw_wctl got=%0h/%0b/%0b exp=3/1/1", WA3Wout, RegWriteWout, MemToRegWout); else passed++;
        total++; if (ALUOutWout !== 32'h100 || MemErrWout !== 1'b0) $display("FAIL zw_alu got=%0h/%0b exp=100/0", ALUOutWout, MemErrWout); else passed++;
        set_idle(); tick();
    endtask

    task automatic test_wait_store();
        int stalls = 0;
        MemWriteM = 1; ALUOutM = 32'h200; WriteDataM = 32'h12345678; WA3M = 5; MemAckIn = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (StallMout === 1'b1) stalls++;
            total++; if ({MemReqOut, MemWeOut} !== 2'b11) $display("FAIL ws_hs%0d got=%0b exp=11", i, {MemReqOut, MemWeOut}); else passed++;
            total++; if (MemAddrOut !== 32'h200 || MemWdOut !== 32'h12345678) $display("FAIL ws_bus%0d got=%0h/%0h exp=200/12345678", i, MemAddrOut, MemWdOut); else passed++;
            tick();
            total++; if ({RegWriteWout, MemToRegWout, PCSrcWout, MemErrWout} !== 4'b0) $display("FAIL ws_bubble%0d got=%0b exp=0", i, {RegWriteWout, MemToRegWout, PCSrcWout, MemErrWout}); else passed++;
            // Upstream changes must not reach the bus while waiting
            ALUOutM = 32'hFFF; WriteDataM = 32'h0;
        end
        total++; if (stalls !== 3) $display("FAIL ws_stallcnt got=%0d exp=3", stalls); else passed++;
        MemAckIn = 1; #1;
        total++; if (StallMout !== 1'b0 || MemAddrOut !== 32'h200) $display("FAIL ws_ack got=%0b/%0h exp=0/200", StallMout, MemAddrOut); else passed++;
        tick();
        total++; if (ALUOutWout !== 32'h200 || RegWriteWout !== 1'b0 || MemErrWout !== 1'b0) $display("FAIL ws_done got=%0h/%0b/%0b exp=200/0/0", ALUOutWout, RegWriteWout, MemErrWout); else passed++;
        set_idle(); tick();
    endtask

    task automatic test_timeout();
        int stalls = 0;
        ALUOutM = 32'h300; MemToRegM = 1; RegWriteM = 1; WA3M = 7; MemAckIn = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (StallMout === 1'b1) stalls++;
            tick();
        end
        total++; if (stalls !== 4) $display("FAIL to_stallcnt got=%0d exp=4", stalls); else passed++;
        total++; if (StallMout !== 1'b0 || MemReqOut !== 1'b1) $display("FAIL to_abortcyc got=%0b/%0b exp=0/1", StallMout, MemReqOut); else passed++;
        tick();
        set_idle(); #1;
        total++; if (MemReqOut !== 1'b0) $display("FAIL to_reqdrop got=%0b exp=0", MemReqOut); else passed++;
        total++; if (ReadDataWout !== 32'hDEADBEEF) $display("FAIL to_rdata got=%0h exp=deadbeef", ReadDataWout); else passed++;
        total++; if ({MemErrWout, RegWriteWout, MemToRegWout, PCSrcWout} !== 4'b1000) $display("FAIL to_wctl got=%0b exp=1000", {MemErrWout, RegWriteWout, MemToRegWout, PCSrcWout}); else passed++;
        tick();
        total++; if (MemErrWout !== 1'b0) $display("FAIL to_errpulse got=%0b exp=0", MemErrWout); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        ALUOutM = 32'h400; MemToRegM = 1; RegWriteM = 1; WA3M = 9; MemAckIn = 0;
        tick();
        reset = 1; MemAckIn = 1; MemRdataIn = 32'h99; #1;
        total++; if ({MemReqOut, StallMout} !== 2'b00) $display("FAIL rw_hs got=%0b exp=00", {MemReqOut, StallMout}); else passed++;
        total++; if ({ALUOutWout, ReadDataWout, WA3Wout, RegWriteWout, MemToRegWout, PCSrcWout, MemErrWout} !== 72'h0) $display("FAIL rw_wclear got=%0h exp=0", ALUOutWout); else passed++;
        tick();
        reset = 0; set_idle();
        ALUOutM = 32'd7; RegWriteM = 1; WA3M = 2; #1;
        total++; if (MemReqOut !== 1'b0) $display("FAIL rw_idle got=%0b exp=0", MemReqOut); else passed++;
        tick();
        total++; if (ALUOutWout !== 32'd7 || RegWriteWout !== 1'b1 || ReadDataWout !== 32'h0) $display("FAIL rw_aluop got=%0h/%0b/%0h exp=7/1/0", ALUOutWout, RegWriteWout, ReadDataWout); else passed++;
        set_idle(); tick();
    endtask

    task automatic test_back_to_back();
        ALUOutM = 32'h500; MemToRegM = 1; RegWriteM = 1; WA3M = 1; MemAckIn = 0; #1;
        total++; if ({MemReqOut, StallMout} !== 2'b11) $display("FAIL bb_ld0 got=%0b exp=11", {MemReqOut, StallMout}); else passed++;
        tick();
        MemAckIn = 1; MemRdataIn = 32'h0BADF00D; #1;
        total++; if ({MemReqOut, StallMout} !== 2'b10) $display("FAIL bb_ld1 got=%0b exp=10", {MemReqOut, StallMout}); else passed++;
        tick();
        MemToRegM = 0; RegWriteM = 0; MemWriteM = 1; ALUOutM = 32'h600; WriteDataM = 32'hA5A5; WA3M = 4;
        MemAckIn = 1; MemRdataIn = 32'h0; #1;
        total++; if ({MemReqOut, MemWeOut, StallMout} !== 3'b110 || MemAddrOut !== 32'h600) $display("FAIL bb_st got=%0b/%0h exp=110/600", {MemReqOut, MemWeOut, StallMout}, MemAddrOut); else passed++;
        total++; if (ReadDataWout !== 32'h0BADF00D || WA3Wout !== 4'd1 || RegWriteWout !== 1'b1) $display("FAIL bb_wld got=%0h/%0h/%0b exp=badf00d/1/1", ReadDataWout, WA3Wout, RegWriteWout); else passed++;
        tick();
        total++; if (ALUOutWout !== 32'h600 || RegWriteWout !== 1'b0 || MemToRegWout !== 1'b0) $display("FAIL bb_wst got=%0h/%0b/%0b exp=600/0/0", ALUOutWout, RegWriteWout, MemToRegWout); else passed++;
        set_idle(); tick();
    endtask

`ifdef MEM_BYTE_EN
    task automatic test_byte_en();
        ByteM = 1; MemWriteM = 1; ALUOutM = 32'h203; WriteDataM = 32'h000000AB; MemAckIn = 1; #1;
        total++; if (MemBeOut !== 4'b1000 || MemWdOut !== 32'hABABABAB) $display("FAIL be_store got=%0b/%0h exp=1000/abababab", MemBeOut, MemWdOut); else passed++;
        tick();
        MemWriteM = 0; MemToRegM = 1; RegWriteM = 1; ALUOutM = 32'h201; MemRdataIn = 32'h11223344; #1;
        total++; if (MemBeOut !== 4'b0010) $display("FAIL be_loadbe got=%0b exp=0010", MemBeOut); else passed++;
        tick();
        total++; if (ReadDataWout !== 32'h33) $display("FAIL be_load got=%0h exp=33", ReadDataWout); else passed++;
        set_idle(); tick();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog sim time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_wait_load();
        test_wait_store();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
`ifdef MEM_BYTE_EN
        test_byte_en();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline M stage of the ARM core; sits directly downstream of the execute stage's EX/MEM register.
- Drives the data-memory / memory-mapped camera bus with a req/ack handshake.
- Stalls the pipeline on slow accesses and aborts hung accesses via a watchdog.
- Contains the MEM/WB pipeline register feeding writeback; also returns ALUOutM for E-stage forwarding.

Parameters:
- DATA_W, 32, data/address width.
- MAX_WAIT, 15, max cycles in MEM_WAIT before abort (>=1).

Ports:
- Clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- PCSrcM, RegWriteM, MemToRegM, MemWriteM  in  1 each  M-stage control.
- ALUOutM  in  32  address / ALU result.
- WriteDataM  in  32  store data.
- WA3M  in  4  destination register.
- MemReqOut  out  1  bus request.
- MemWeOut  out  1  bus write enable.
- MemAddrOut  out  32  bus address.
- MemWdOut  out  32  bus write data.
- MemBeOut  out  4  byte enables.
- MemRdataIn  in  32  bus read data.
- MemAckIn  in  1  bus acknowledge.
- StallMout  out  1  to hazard unit; freezes F/D/E/M.
- ALUOutMout  out  32  forwarding path (= ALUOutM).
- PCSrcWout, RegWriteWout, MemToRegWout  out  1 each  W-stage control.
- ReadDataWout  out  32  load data.
- ALUOutWout  out  32  ALU result to W.
- WA3Wout  out  4  destination register to W.
- MemErrWout  out  1  watchdog abort flag, one cycle.

Behaviour:
- Access valid: acc = MemToRegM | MemWriteM. A load is MemToRegM=1.
- States: MEM_IDLE and MEM_WAIT. Counter cnt is width clog2(MAX_WAIT+1).
- MEM_IDLE, acc=0:
  - MemReqOut=0.
  - W register loads M controls/data normally; ReadDataW=0.
- MEM_IDLE, acc=1:
  - MemReqOut=1 combinationally; MemWeOut=MemWriteM.
  - Latch ALUOutM and WriteDataM into hold registers.
  - If MemAckIn the same cycle: zero-wait access. W loads, ReadDataW=MemRdataIn, StallMout=0.
  - Else: StallMout=1, go to MEM_WAIT, cnt=0, W register loads a bubble (all W controls 0).
- MEM_WAIT:
  - MemReqOut=1. Address and data driven from hold registers (stable regardless of inputs).
  - MemAckIn=1: StallMout=0, W loads latched controls + MemRdataIn, go to MEM_IDLE.
  - No ack and cnt==MAX_WAIT-1: abort.
    - Drop MemReqOut next cycle; StallMout=0.
    - W loads with RegWriteW=0, PCSrcW=0, MemToRegW=0, ReadDataW=32'hDEADBEEF, MemErrW=1.
    - Go to MEM_IDLE.
  - Otherwise: cnt++, StallMout=1, bubble into W.
- Back-to-back accesses: after completion, the next acc in MEM_IDLE starts without an idle cycle.
- MemErrWout is high exactly one cycle per abort; cleared on the next W load.
- MemBeOut=4'hF for word accesses.
- ALUOutMout = ALUOutM, combinational, independent of state.
- Reset (asserted at any time, including mid-WAIT):
  - Immediately: state=MEM_IDLE, cnt=0, MemReqOut=0, StallMout=0.
  - All W outputs and hold registers = 0; MemErrWout=0.
  - An ack arriving during reset is ignored.

Optional Feature:
- Macro: MEM_BYTE_EN.
- Defined:
  - Adds input ByteM (1).
  - Byte store: MemWdOut = {4{WriteDataM[7:0]}}; MemBeOut = one-hot of addr[1:0] (00->0001, 11->1000).
  - Byte load: ReadDataW = zero-extended byte from lane addr[1:0].
  - ByteM is latched with the hold registers.
- Undefined:
  - Port ByteM absent; MemBeOut fixed 4'hF; word accesses only.

Decomposition:
- Package mem_pkg:
  - enum mem_state_t {MEM_IDLE, MEM_WAIT}.
  - Constant MEM_ABORT_DATA = 32'hDEADBEEF.
  - Constant BE_WORD = 4'hF.
- Sub-module pipeMemWb: the MEM/WB register.
  - Inputs: load data, bubble select, control/data fields.
  - Clock and asynchronous reset to 0.
- FSM, watchdog counter, hold registers and byte logic stay in memory_stage.

Test Plan:
- Zero-wait load: ALUOutM=0x100, MemToRegM=1, RegWriteM=1, WA3M=3, ack same cycle, rdata=0xCAFEF00D -> next cycle ReadDataW=0xCAFEF00D, WA3W=3, RegWriteW=1, StallM never 1.
- 3-wait store: MemWriteM=1, addr=0x200, wd=0x12345678, ack on 4th cycle -> StallM=1 for 3 cycles; MemAddr/MemWd stable; 3 bubbles into W; then MemWriteM path completes; RegWriteW=0.
- Timeout: MAX_WAIT=4, load, no ack -> StallM high 4 cycles; MemReq drops; ReadDataW=0xDEADBEEF, MemErrW=1 for 1 cycle, RegWriteW=0.
- Reset mid-WAIT: assert reset cycle 2 of a wait -> MemReq=0, StallM=0, all W outputs 0 asynchronously; after release, an ALU-only op (acc=0, ALUOutM=7) passes to ALUOutW=7 in 1 cycle.
- Back-to-back: load (1 wait) then store (0 wait) -> no idle cycle between requests; W order preserved.
- MEM_BYTE_EN: byte store 0xAB at 0x203 -> MemBe=1000, MemWd=0xABABABAB; byte load at 0x201 with rdata 0x11223344 -> ReadDataW=0x33.
